data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of the number of 32-bit words stored (256 words).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted between request acceptance and response (legal range 0..15).
REQ-003 clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-005 req  input  1  requester asserts to present a transaction; held until ack is seen.
REQ-006 we  input  1  1 = store, 0 = load; valid with req.
REQ-007 addr  input  16  byte address; valid with req.
REQ-008 wdata  input  32  store data; valid with req.
REQ-009 be  input  4  byte enables for stores, be[0] = bits 7:0; ignored on loads.
REQ-010 ack  output  1  one-cycle response strobe.
REQ-011 err  output  1  error flag, valid only while ack=1.
REQ-012 rdata  output  32  load data, valid only while ack=1 on an error-free load.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-015 IDLE: req=1 on a rising edge SHALL latch we, addr, wdata and be, then go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0); req=0 stays in IDLE.
REQ-016 WAIT: a down-counter loaded with WAIT_CYCLES-1 on entry SHALL decrement each edge; the FSM SHALL go to RESP on the edge where the counter reads 0.
REQ-017 RESP SHALL last exactly one cycle and return unconditionally to IDLE; ack=1 only in RESP.
REQ-018 With acceptance at edge n, ack SHALL be high between edges n+WAIT_CYCLES and n+WAIT_CYCLES+1.
REQ-019 req, we, addr, wdata and be SHALL be ignored outside IDLE; only latched values are used.
REQ-020 Back-to-back: req still high during the IDLE cycle after RESP SHALL be accepted as a new transaction (minimum one IDLE cycle between transactions).
REQ-021 Word index SHALL be addr[DEPTH_LOG2+1:2].
REQ-022 Misaligned (addr[1:0]!=0) or out-of-range (any addr bit above DEPTH_LOG2+1 set) SHALL give err=1, rdata=0, and no memory update.
REQ-023 An error-free store SHALL update only bytes with be set, on the edge entering RESP; be=4'b0000 updates nothing and gives err=0.
REQ-024 An error-free load SHALL register the full addressed word into rdata on the edge entering RESP.
REQ-025 A load issued after a store to the same word SHALL return the stored bytes merged with the previous contents.
REQ-026 Outside RESP, ack=0, err=0 and rdata=0.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, counter 0, ack=0, err=0, rdata=0, busy=0, and clear all memory words to 0.
REQ-028 Reset during WAIT or RESP SHALL abandon the transaction; a pending store is not performed.
REQ-029 After rst rises, the first rising edge with req=1 SHALL be accepted normally.

Verification
REQ-030 WAIT_CYCLES=2: store addr=0x0010, wdata=0xDEADBEEF, be=4'hF accepted at edge n -> ack=1, err=0 between edges n+2 and n+3; busy=1 from n to n+3.
REQ-031 Then load addr=0x0010 -> rdata=0xDEADBEEF with ack; store be=4'b0011, wdata=0x00001234, then load -> rdata=0xDEAD1234.
REQ-032 Load addr=0x0013 -> ack with err=1, rdata=0; load addr=0x0400 (DEPTH_LOG2=8) -> err=1; memory unchanged.
REQ-033 req held high across two transactions -> two single-cycle ack pulses separated by the IDLE cycle plus WAIT_CYCLES cycles.
REQ-034 rst=0 mid-WAIT of a store to 0x0020 -> ack never asserted; after release, load 0x0020 -> rdata=0x00000000.
REQ-035 WAIT_CYCLES=0 build: load accepted at edge n -> ack high between edges n and n+1.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a req/ack handshake. Each accepted
// transaction spends WAIT_CYCLES wait states, then gives a one-cycle response.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [15:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic [31:0]         r_mem [DEPTH];
  logic                r_err;
  logic [31:0]         r_rdata;

  logic                w_op_we;
  logic [15:0]         w_op_addr;
  logic [31:0]         w_op_wdata;
  logic [3:0]          w_op_be;
  logic                w_op_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                w_enter_resp;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) w_next = S_RESP;
          else                  w_next = S_WAIT;
        end
      end
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accepting edge itself, so the
  // operand must come straight from the inputs rather than the latches.
  always_comb begin
    w_op_we    = r_we;
    w_op_addr  = r_addr;
    w_op_wdata = r_wdata;
    w_op_be    = r_be;
    if (r_state == S_IDLE) begin
      w_op_we    = we;
      w_op_addr  = addr;
      w_op_wdata = wdata;
      w_op_be    = be;
    end
    w_op_err     = (w_op_addr[1:0] != 2'b00) || ((w_op_addr >> (DEPTH_LOG2 + 2)) != '0);
    w_idx        = w_op_addr[DEPTH_LOG2+1:2];
    w_enter_resp = (w_next == S_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_be    <= be;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Response registers hold a value only for the single RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_err   <= 1'b0;
      r_rdata <= '0;
      if (w_enter_resp) begin
        r_err <= w_op_err;
        if (!w_op_err && !w_op_we) r_rdata <= r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_enter_resp && w_op_we && !w_op_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_op_be[b]) r_mem[w_idx][8*b +: 8] <= w_op_wdata[8*b +: 8];
      end
    end
  end

  assign ack   = (r_state == S_RESP);
  assign err   = r_err;
  assign rdata = r_rdata;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: a WAIT_CYCLES=2 instance for the main flows and a
// WAIT_CYCLES=0 instance for the zero-wait-state latency.
module tb_data_mem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req0, we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack, err, busy;
  logic [31:0] rdata;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy)
  );

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack0), .err(err0), .rdata(rdata0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance; inputs are scrambled after
  // acceptance so any use of live inputs outside IDLE shows up.
  task automatic txn(input string tag, input logic w, input logic [15:0] a,
                     input logic [31:0] d, input logic [3:0] b,
                     input logic e_err, input logic [31:0] e_rd);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    check({tag, "_busy_acc"}, {31'd0, busy}, 32'd1);
    check({tag, "_ack_acc"},  {31'd0, ack},  32'd0);
    req = 1'b0; we = ~w; addr = a ^ 16'h0004; wdata = ~d; be = ~b;
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      check({tag, "_ack_wait"}, {31'd0, ack}, 32'd0);
    end
    @(posedge clk); #1;
    check({tag, "_ack"},   {31'd0, ack},  32'd1);
    check({tag, "_err"},   {31'd0, err},  {31'd0, e_err});
    check({tag, "_rdata"}, rdata, e_rd);
    check({tag, "_busy"},  {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_ack_after"},   {31'd0, ack},  32'd0);
    check({tag, "_busy_after"},  {31'd0, busy}, 32'd0);
    check({tag, "_rdata_after"}, rdata, 32'd0);
    check({tag, "_err_after"},   {31'd0, err},  32'd0);
  endtask

  task automatic txn0(input string tag, input logic w, input logic [15:0] a,
                      input logic [31:0] d, input logic [3:0] b,
                      input logic e_err, input logic [31:0] e_rd);
    @(negedge clk);
    req0 = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    check({tag, "_ack0"},   {31'd0, ack0},  32'd1);
    check({tag, "_err0"},   {31'd0, err0},  {31'd0, e_err});
    check({tag, "_rdata0"}, rdata0, e_rd);
    check({tag, "_busy0"},  {31'd0, busy0}, 32'd1);
    req0 = 1'b0; we = ~w; addr = a ^ 16'h0004; wdata = ~d; be = ~b;
    @(posedge clk); #1;
    check({tag, "_ack0_after"},  {31'd0, ack0},  32'd0);
    check({tag, "_busy0_after"}, {31'd0, busy0}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; be = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   {31'd0, ack},  32'd0);
    check("rst_err",   {31'd0, err},  32'd0);
    check("rst_rdata", rdata,         32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_ack0",  {31'd0, ack0}, 32'd0);
    @(negedge clk) rst = 1'b1;

    txn("st_full",   1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    txn("ld_full",   1'b0, 16'h0010, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF);
    txn("st_lo",     1'b1, 16'h0010, 32'h00001234, 4'b0011, 1'b0, 32'h0);
    txn("ld_merge",  1'b0, 16'h0010, 32'h0,        4'h0, 1'b0, 32'hDEAD1234);
    txn("st_be0",    1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0);
    txn("ld_be0",    1'b0, 16'h0010, 32'h0,        4'h0, 1'b0, 32'hDEAD1234);
    txn("ld_mis",    1'b0, 16'h0013, 32'h0,        4'h0, 1'b1, 32'h0);
    txn("ld_oor",    1'b0, 16'h0400, 32'h0,        4'h0, 1'b1, 32'h0);
    txn("st_mis",    1'b1, 16'h0012, 32'h11111111, 4'hF, 1'b1, 32'h0);
    txn("st_oor",    1'b1, 16'h0410, 32'h22222222, 4'hF, 1'b1, 32'h0);
    txn("ld_unchg",  1'b0, 16'h0010, 32'h0,        4'h0, 1'b0, 32'hDEAD1234);
    txn("st_top",    1'b1, 16'h03FC, 32'hAABBCCDD, 4'b1100, 1'b0, 32'h0);
    txn("ld_top",    1'b0, 16'h03FC, 32'h0,        4'h0, 1'b0, 32'hAABB0000);

    // req held high across two loads: ack after edges n+2 and n+6
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'h0010; be = 4'h0;
    for (int k = 0; k <= 7; k++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_ack_e%0d", k), {31'd0, ack},
            ((k == 2) || (k == 6)) ? 32'd1 : 32'd0);
      if (k == 2 || k == 6) check($sformatf("b2b_rdata_e%0d", k), rdata, 32'hDEAD1234);
      if (k == 3) check("b2b_idle_busy", {31'd0, busy}, 32'd0);
      if (k == 4) check("b2b_acc2_busy", {31'd0, busy}, 32'd1);
      if (k == 6) req = 1'b0;
    end

    // reset during WAIT of a store to 0x0020
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 32'h12345678; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    check("rw_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rw_busy_rst", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("rw_ack_rst", {31'd0, ack}, 32'd0);
    end
    @(negedge clk) rst = 1'b1;
    txn("ld_abandon", 1'b0, 16'h0020, 32'h0, 4'h0, 1'b0, 32'h0);
    txn("ld_clr10",   1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 32'h0);
    txn("ld_clrtop",  1'b0, 16'h03FC, 32'h0, 4'h0, 1'b0, 32'h0);

    txn0("w0_st",  1'b1, 16'h0010, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
    txn0("w0_ld",  1'b0, 16'h0010, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D);
    txn0("w0_mis", 1'b0, 16'h0011, 32'h0,        4'h0, 1'b1, 32'h0);
    check("w0_other_idle", {31'd0, ack}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
